// File: rtl/sobel_win_pkg.sv
// Purpose: shared types and constants for the Sobel 3x3 window buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sobel_win_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int WIN = 3;

    // Tap indices, row-major: top row, middle row, bottom row.
    localparam int TL = 0;
    localparam int TC = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MC = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BC = 7;
    localparam int BR = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_delay.sv
// Purpose: DEPTH-sample delay line (RAM plus one read/write pointer) advancing on shift_en.
// Latency: data_o is the sample written DEPTH shifts ago.
// Backpressure: none; holds while shift_en is low.
module sobel_line_delay
    import sobel_win_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 320
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int PW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (shift_en) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

    // Read-before-write on the same slot gives exactly DEPTH samples of delay.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[ptr] <= data_i;
        end
    end

    assign data_o = mem[ptr];

endmodule

// File: rtl/sobel_window_buffer.sv
// Purpose: 3x3 sliding-window generator over a raster pixel stream; SOBEL_WIN_ZERO_PAD_EN selects zero-padded border output.
// Latency: window registered one cycle after the accept (or flush step) that completes it.
// Backpressure: ready_o drops only while pad mode flushes the last row; valid_i gaps freeze all state.
module sobel_window_buffer
    import sobel_win_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 240,
    parameter int COLS       = 320
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] d0_o,
    output logic [DATA_WIDTH-1:0] d1_o,
    output logic [DATA_WIDTH-1:0] d2_o,
    output logic [DATA_WIDTH-1:0] d3_o,
    output logic [DATA_WIDTH-1:0] d4_o,
    output logic [DATA_WIDTH-1:0] d5_o,
    output logic [DATA_WIDTH-1:0] d6_o,
    output logic [DATA_WIDTH-1:0] d7_o,
    output logic [DATA_WIDTH-1:0] d8_o,
    output logic                  valid_o,
    output logic                  done_o
);

    localparam int RW = cnt_w(ROWS);
    localparam int CW = cnt_w(COLS);

    state_t state, state_nxt;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic in_flush, accept, step, emit, win_last, pix_last, done;

    logic [DATA_WIDTH-1:0] pix, ld1_q, ld2_q;
    logic [DATA_WIDTH-1:0] sh      [WIN][WIN];
    logic [DATA_WIDTH-1:0] tap     [WIN*WIN];
    logic [DATA_WIDTH-1:0] out_tap [WIN*WIN];
    logic [DATA_WIDTH-1:0] win_q   [WIN*WIN];

`ifdef SOBEL_WIN_ZERO_PAD_EN
    logic [RW-1:0] cen_row;
    logic [CW-1:0] cen_col;
    assign in_flush = (state == ST_FLUSH);
`else
    assign in_flush = 1'b0;
`endif

    assign ready_o  = !in_flush;
    assign accept   = valid_i && ready_o;
    assign step     = accept || in_flush;
    assign pix      = in_flush ? '0 : data_i;
    assign pix_last = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));
    assign done     = emit && win_last;

`ifdef SOBEL_WIN_ZERO_PAD_EN
    // Centre trails the latest step by COLS+1 positions; flush steps always emit.
    assign emit     = in_flush || (accept && ((row > RW'(1)) || ((row == RW'(1)) && (col != '0))));
    assign win_last = (cen_row == RW'(ROWS - 1)) && (cen_col == CW'(COLS - 1));
`else
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign win_last = pix_last;
`endif

    sobel_line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_ld1 (
        .clk(clk), .rst(rst), .shift_en(step), .data_i(pix), .data_o(ld1_q)
    );

    sobel_line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(COLS)) u_ld2 (
        .clk(clk), .rst(rst), .shift_en(step), .data_i(ld1_q), .data_o(ld2_q)
    );

    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            tap[i*WIN + 0] = sh[i][1];
            tap[i*WIN + 1] = sh[i][2];
        end
        tap[TR] = ld2_q;
        tap[MR] = ld1_q;
        tap[BR] = pix;
    end

    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                out_tap[i*WIN + j] = tap[i*WIN + j];
`ifdef SOBEL_WIN_ZERO_PAD_EN
                if ((j == 0 && cen_col == '0) || (j == WIN - 1 && cen_col == CW'(COLS - 1)) ||
                    (i == 0 && cen_row == '0) || (i == WIN - 1 && cen_row == RW'(ROWS - 1))) begin
                    out_tap[i*WIN + j] = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIN; i++) begin
                for (int j = 0; j < WIN; j++) begin
                    sh[i][j] <= '0;
                end
            end
        end else if (step) begin
            for (int i = 0; i < WIN; i++) begin
                for (int j = 0; j < WIN; j++) begin
                    sh[i][j] <= tap[i*WIN + j];
                end
            end
        end
    end

    // Frame end clears the counters so IDLE always starts at (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (done) begin
                row <= '0;
                col <= '0;
            end else if (col == CW'(COLS - 1)) begin
                col <= '0;
                row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

`ifdef SOBEL_WIN_ZERO_PAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cen_row <= '0;
            cen_col <= '0;
        end else if (emit) begin
            if (done) begin
                cen_row <= '0;
                cen_col <= '0;
            end else if (cen_col == CW'(COLS - 1)) begin
                cen_col <= '0;
                cen_row <= cen_row + RW'(1);
            end else begin
                cen_col <= cen_col + CW'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_RUN;
            end
            ST_RUN: begin
`ifdef SOBEL_WIN_ZERO_PAD_EN
                if (accept && pix_last) state_nxt = ST_FLUSH;
`else
                if (accept && pix_last) state_nxt = ST_IDLE;
`endif
            end
            ST_FLUSH: begin
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            for (int k = 0; k < WIN*WIN; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            valid_o <= emit;
            done_o  <= done;
            if (emit) begin
                for (int k = 0; k < WIN*WIN; k++) begin
                    win_q[k] <= out_tap[k];
                end
            end
        end
    end

    assign d0_o = win_q[TL];
    assign d1_o = win_q[TC];
    assign d2_o = win_q[TR];
    assign d3_o = win_q[ML];
    assign d4_o = win_q[MC];
    assign d5_o = win_q[MR];
    assign d6_o = win_q[BL];
    assign d7_o = win_q[BC];
    assign d8_o = win_q[BR];

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Bench for sobel_window_buffer at ROWS=COLS=4; frame-image reference model, per-cycle compare.
module tb_sobel_window_buffer;

    localparam int R = 4;
    localparam int C = 4;
    localparam int N = R * C;
`ifdef SOBEL_WIN_ZERO_PAD_EN
    localparam int WPF = N;
`else
    localparam int WPF = (R - 2) * (C - 2);
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o, valid_o, done_o;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] dw [9];

    assign dw[0] = d0; assign dw[1] = d1; assign dw[2] = d2;
    assign dw[3] = d3; assign dw[4] = d4; assign dw[5] = d5;
    assign dw[6] = d6; assign dw[7] = d7; assign dw[8] = d8;

    sobel_window_buffer #(.DATA_WIDTH(8), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .d0_o(d0), .d1_o(d1), .d2_o(d2), .d3_o(d3), .d4_o(d4),
        .d5_o(d5), .d6_o(d6), .d7_o(d7), .d8_o(d8),
        .valid_o(valid_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [8:0][7:0] t;
        logic            done;
        logic [15:0]     acc;
    } win_rec_t;

    win_rec_t   wlog [$];
    int         acc_total = 0;
    int         acc_base  = 0;
    int         low_run = 0;
    int         last_low_run = 0;

    // Reference model: the frame as an image; each window is read straight from it.
    logic [7:0] img [R][C];
    int         k;
    logic [7:0] exp_win [9];
    bit         exp_vld, exp_done, exp_rdy;

    function automatic logic [7:0] pix_at(input int r, input int c);
        if (r < 0 || r >= R || c < 0 || c >= C) return 8'h00;
        return img[r][c];
    endfunction

    initial begin
        bit in_flush, stp;
        int m;
        k = 0; exp_vld = 0; exp_done = 0; exp_rdy = 1;
        for (int i = 0; i < 9; i++) exp_win[i] = 8'h00;
        forever begin
            @(posedge clk);
            exp_vld = 0;
            exp_done = 0;
            if (rst_n) begin
                in_flush = (k >= N);
                stp = in_flush || valid_i;
                if (stp) begin
                    if (!in_flush) begin
                        img[k / C][k % C] = data_i;
                        acc_total++;
                    end
`ifdef SOBEL_WIN_ZERO_PAD_EN
                    if (k >= C + 1) begin
                        m = k - C - 1;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                exp_win[i*3 + j] = pix_at(m / C - 1 + i, m % C - 1 + j);
                        exp_vld = 1;
                        exp_done = (m == N - 1);
                    end
`else
                    if (k / C >= 2 && k % C >= 2) begin
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                exp_win[i*3 + j] = pix_at(k / C - 2 + i, k % C - 2 + j);
                        exp_vld = 1;
                        exp_done = (k == N - 1);
                    end
`endif
                    k = exp_done ? 0 : k + 1;
                end
                exp_rdy = (k < N);
            end
            @(negedge clk);
            if (!rst_n) begin
                k = 0; exp_vld = 0; exp_done = 0; exp_rdy = 1; low_run = 0;
                for (int i = 0; i < 9; i++) exp_win[i] = 8'h00;
            end
            chk("valid_o", int'(valid_o), int'(exp_vld));
            chk("done_o", int'(done_o), int'(exp_done));
            chk("ready_o", int'(ready_o), int'(exp_rdy));
            for (int i = 0; i < 9; i++) chk($sformatf("d%0d_o", i), int'(dw[i]), int'(exp_win[i]));
            if (valid_o) begin
                win_rec_t rec;
                for (int i = 0; i < 9; i++) rec.t[i] = dw[i];
                rec.done = done_o;
                rec.acc = 16'(acc_total - acc_base);
                wlog.push_back(rec);
            end
            if (!ready_o) low_run++;
            else if (low_run != 0) begin last_low_run = low_run; low_run = 0; end
        end
    end

    task automatic send_pixel(input logic [7:0] v);
        bit acc = 0;
        int guard = 0;
        valid_i = 1'b1;
        data_i = v;
        while (!acc && guard <= 50) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        valid_i = 1'b0;
        data_i = 8'($urandom);
    endtask

    // kind: 0 = 16r+c, 1 = 0xFF-(16r+c), 2 = random; gap: 0 none, 1 toggle, 2 random
    task automatic send_frame(input int kind, input int gap, input int npix);
        logic [7:0] v;
        for (int p = 0; p < npix; p++) begin
            case (kind)
                0:       v = 8'(16 * (p / C) + p % C);
                1:       v = 8'(255 - (16 * (p / C) + p % C));
                default: v = 8'($urandom);
            endcase
            send_pixel(v);
            if (gap == 1) begin @(posedge clk); #1; end
            else if (gap == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic flush_hold();
        int guard = 0;
        valid_i = 1'b1;
        data_i = 8'hAA;
        do begin
            @(negedge clk);
            guard++;
        end while (!ready_o && guard < 50);
        valid_i = 1'b0;
        chk("flush_hold_ready_back", int'(ready_o), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_ref(input string tag, input int b);
        chk({tag, "_nwin"}, wlog.size() - b >= WPF ? 1 : 0, 1);
        if (wlog.size() - b >= WPF) begin
`ifdef SOBEL_WIN_ZERO_PAD_EN
            chk({tag, "_first_acc"}, int'(wlog[b].acc), 6);
            for (int i = 0; i < 4; i++) chk({tag, "_first_top"}, int'(wlog[b].t[i]), 0);
            chk({tag, "_first_d4"}, int'(wlog[b].t[4]), 8'h00);
            chk({tag, "_first_d5"}, int'(wlog[b].t[5]), 8'h01);
            chk({tag, "_first_d6"}, int'(wlog[b].t[6]), 8'h00);
            chk({tag, "_first_d7"}, int'(wlog[b].t[7]), 8'h10);
            chk({tag, "_first_d8"}, int'(wlog[b].t[8]), 8'h11);
            chk({tag, "_last_d4"}, int'(wlog[b+WPF-1].t[4]), 8'h33);
            for (int i = 5; i < 9; i++) chk({tag, "_last_pad"}, int'(wlog[b+WPF-1].t[i]), 0);
`else
            chk({tag, "_first_acc"}, int'(wlog[b].acc), 11);
            chk({tag, "_first_d0"}, int'(wlog[b].t[0]), 8'h00);
            chk({tag, "_first_d4"}, int'(wlog[b].t[4]), 8'h11);
            chk({tag, "_first_d8"}, int'(wlog[b].t[8]), 8'h22);
            chk({tag, "_last_d4"}, int'(wlog[b+WPF-1].t[4]), 8'h22);
            chk({tag, "_last_d8"}, int'(wlog[b+WPF-1].t[8]), 8'h33);
`endif
            chk({tag, "_last_done"}, int'(wlog[b+WPF-1].done), 1);
            chk({tag, "_first_not_done"}, int'(wlog[b].done), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Continuous reference frame.
        wlog.delete(); acc_base = acc_total; last_low_run = 0;
        send_frame(0, 0, N);
        idle(C + 4);
        chk("s1_nwin_exact", wlog.size(), WPF);
        check_ref("s1", 0);
`ifdef SOBEL_WIN_ZERO_PAD_EN
        chk("s1_ready_low_cycles", last_low_run, C + 1);
`else
        chk("s1_ready_low_cycles", last_low_run, 0);
`endif

        // Same frame, valid toggling.
        wlog.delete(); acc_base = acc_total;
        send_frame(0, 1, N);
        idle(C + 4);
        chk("s2_nwin_exact", wlog.size(), WPF);
        if (wlog.size() == WPF) begin
            chk("s2_first_d4", int'(wlog[0].t[4]), 8'h11 * ((WPF == N) ? 0 : 1));
            chk("s2_last_done", int'(wlog[WPF-1].done), 1);
        end

`ifdef SOBEL_WIN_ZERO_PAD_EN
        // Valid held high with junk through FLUSH, then a fresh frame.
        wlog.delete(); acc_base = acc_total;
        send_frame(0, 0, N);
        flush_hold();
        acc_base = acc_total;
        send_frame(0, 0, N);
        idle(C + 4);
        chk("pad_hold_nwin", wlog.size(), 2 * WPF);
        if (wlog.size() == 2 * WPF) begin
            chk("pad_hold_next_d4", int'(wlog[WPF].t[4]), 8'h00);
            chk("pad_hold_next_d8", int'(wlog[WPF].t[8]), 8'h11);
        end
`endif

        // Random data with random gaps.
        repeat (3) begin
            send_frame(2, 2, N);
        end
        idle(C + 4);

        // Reset mid-frame after 7 accepts.
        send_frame(2, 0, 7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_done_o", int'(done_o), 0);
        chk("rst_ready_o", int'(ready_o), 1);
        for (int i = 0; i < 9; i++) chk($sformatf("rst_d%0d", i), int'(dw[i]), 0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        wlog.delete(); acc_base = acc_total;
        send_frame(0, 0, N);
        idle(C + 4);
        chk("s4_nwin_exact", wlog.size(), WPF);
        check_ref("s4", 0);

        // Back-to-back frames.
        wlog.delete(); acc_base = acc_total;
        send_frame(0, 0, N);
        send_frame(1, 0, N);
        idle(C + 4);
        ndone = 0;
        foreach (wlog[i]) if (wlog[i].done) ndone++;
        chk("b2b_done_count", ndone, 2);
        chk("b2b_nwin", wlog.size(), 2 * WPF);
        if (wlog.size() == 2 * WPF) begin
`ifdef SOBEL_WIN_ZERO_PAD_EN
            chk("b2b_f2_d0", int'(wlog[WPF].t[0]), 8'h00);
            chk("b2b_f2_d4", int'(wlog[WPF].t[4]), 8'hFF);
            chk("b2b_f2_d8", int'(wlog[WPF].t[8]), 8'hEE);
`else
            chk("b2b_f2_d0", int'(wlog[WPF].t[0]), 8'hFF);
            chk("b2b_f2_d4", int'(wlog[WPF].t[4]), 8'hEE);
            chk("b2b_f2_d8", int'(wlog[WPF].t[8]), 8'hDD);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
